// File: rtl/vga_pkg.sv
// Shared timing constants and phase encoding for the VGA timing generator.
// Defaults describe 800x600 @ 72 Hz on a 50 MHz pixel clock.
package vga_pkg;

  // Width of the signed spot coordinates and of the phase down-counters
  localparam int POS_W = 11;
  localparam int CNT_W = 11;

  // Horizontal timing in pixels
  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 56;
  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;

  // Vertical timing in lines
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 37;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;

  // Phases of one axis, in the order they are visited
  typedef enum logic [1:0] {
    PH_FP     = 2'd0,
    PH_SYNC   = 2'd1,
    PH_BP     = 2'd2,
    PH_ACTIVE = 2'd3
  } phase_e;

  // Phase that follows ph along an axis
  function automatic phase_e next_phase(input phase_e ph);
    phase_e nxt;
    case (ph)
      PH_FP:     nxt = PH_SYNC;
      PH_SYNC:   nxt = PH_BP;
      PH_BP:     nxt = PH_ACTIVE;
      PH_ACTIVE: nxt = PH_FP;
      default:   nxt = PH_FP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_phase_ctr.sv
// One timing axis: a FP->SYNC->BP->ACTIVE phase FSM driven by a per-phase
// down-counter, plus the signed position (negative in blanking, 0.. in active).
module vga_phase_ctr
  import vga_pkg::*;
#(
  parameter int LEN_FP     = H_FP,
  parameter int LEN_SYNC   = H_SYNC,
  parameter int LEN_BP     = H_BP,
  parameter int LEN_ACTIVE = H_ACTIVE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    adv_i,
  output logic signed [POS_W-1:0] pos_o,
  output phase_e                  phase_o,
  output logic                    wrap_o
);

  localparam int BLANK = LEN_FP + LEN_SYNC + LEN_BP;
  localparam logic signed [POS_W-1:0] POS_FIRST = POS_W'(-BLANK);

  phase_e                  phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [POS_W-1:0] pos_q, pos_d;

  // Down-counter reload value for a phase (length minus one)
  function automatic logic [CNT_W-1:0] len_m1(input phase_e ph);
    logic [CNT_W-1:0] v;
    case (ph)
      PH_FP:     v = CNT_W'(LEN_FP - 1);
      PH_SYNC:   v = CNT_W'(LEN_SYNC - 1);
      PH_BP:     v = CNT_W'(LEN_BP - 1);
      PH_ACTIVE: v = CNT_W'(LEN_ACTIVE - 1);
      default:   v = CNT_W'(LEN_FP - 1);
    endcase
    return v;
  endfunction

  // Next-state: count down inside a phase, hop to the next phase at zero
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    wrap_o  = 1'b0;
    if (adv_i) begin
      if (cnt_q == {CNT_W{1'b0}}) begin
        phase_d = next_phase(phase_q);
        cnt_d   = len_m1(next_phase(phase_q));
      end else begin
        cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((phase_q == PH_ACTIVE) && (cnt_q == {CNT_W{1'b0}})) begin
        wrap_o = 1'b1;
        pos_d  = POS_FIRST;
      end else begin
        pos_d  = pos_q + 11'sd1;
      end
    end else begin
      wrap_o = 1'b0;
    end
  end

  // State register; reset parks the axis at the first front-porch position
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= PH_FP;
      cnt_q   <= CNT_W'(LEN_FP - 1);
      pos_q   <= POS_FIRST;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  assign pos_o   = pos_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical phase counters produce the spot
// coordinate for renderers; syncs, blank and colour are delayed to match the
// renderer latency and presented as registered monitor outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HACTIVE  = H_ACTIVE,
  parameter int HFP      = H_FP,
  parameter int HSYNC    = H_SYNC,
  parameter int HBP      = H_BP,
  parameter int VACTIVE  = V_ACTIVE,
  parameter int VFP      = V_FP,
  parameter int VSYNC    = V_SYNC,
  parameter int VBP      = V_BP,
  parameter int PIPE_LAT = 1,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic signed [POS_W-1:0] spotX,
  output logic signed [POS_W-1:0] spotY,
  output logic                    frame_start,
  output logic                    line_start,
  input  logic [7:0]              pix_r,
  input  logic [7:0]              pix_g,
  input  logic [7:0]              pix_b,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank
);

  localparam logic signed [POS_W-1:0] X_FIRST = POS_W'(-(HFP + HSYNC + HBP));
  localparam logic signed [POS_W-1:0] Y_FIRST = POS_W'(-(VFP + VSYNC + VBP));

  // run_q holds the counters for one cycle after reset so that the first
  // spot (-HBLANK,-VBLANK) is presented with frame_start/line_start high.
  logic         run_q;
  phase_e       h_phase_s, v_phase_s;
  logic         h_wrap_s;
  logic         raw_blank_s, hs_lvl_s, vs_lvl_s, act_dly_s;
  logic [PIPE_LAT:0]   blank_sr_q, hs_sr_q, vs_sr_q;
  logic [PIPE_LAT+1:0] blank_tap_s, hs_tap_s, vs_tap_s;
  logic [7:0]   vga_r_q, vga_g_q, vga_b_q;

  vga_phase_ctr #(
    .LEN_FP(HFP), .LEN_SYNC(HSYNC), .LEN_BP(HBP), .LEN_ACTIVE(HACTIVE)
  ) u_h_ctr (
    .clk(clk), .reset_n(reset_n), .adv_i(run_q),
    .pos_o(spotX), .phase_o(h_phase_s), .wrap_o(h_wrap_s)
  );

  vga_phase_ctr #(
    .LEN_FP(VFP), .LEN_SYNC(VSYNC), .LEN_BP(VBP), .LEN_ACTIVE(VACTIVE)
  ) u_v_ctr (
    .clk(clk), .reset_n(reset_n), .adv_i(h_wrap_s),
    .pos_o(spotY), .phase_o(v_phase_s), .wrap_o()
  );

  // Raw (undelayed) sync levels and blank; taps[k] is the raw value k cycles ago
  always_comb begin
    raw_blank_s = ~((h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE));
    hs_lvl_s    = (h_phase_s == PH_SYNC) ? HS_POL : ~HS_POL;
    vs_lvl_s    = (v_phase_s == PH_SYNC) ? VS_POL : ~VS_POL;
    blank_tap_s = {blank_sr_q, raw_blank_s};
    hs_tap_s    = {hs_sr_q, hs_lvl_s};
    vs_tap_s    = {vs_sr_q, vs_lvl_s};
    act_dly_s   = ~blank_tap_s[PIPE_LAT];
  end

  // Start-of-hold flag plus sync/blank delay lines
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      blank_sr_q <= {(PIPE_LAT+1){1'b1}};
      hs_sr_q    <= {(PIPE_LAT+1){~HS_POL}};
      vs_sr_q    <= {(PIPE_LAT+1){~VS_POL}};
    end else begin
      run_q      <= 1'b1;
      blank_sr_q <= blank_tap_s[PIPE_LAT:0];
      hs_sr_q    <= hs_tap_s[PIPE_LAT:0];
      vs_sr_q    <= vs_tap_s[PIPE_LAT:0];
    end
  end

  // Colour register: pass renderer colour only for spots that were active
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_r_q <= 8'd0;
      vga_g_q <= 8'd0;
      vga_b_q <= 8'd0;
    end else if (act_dly_s) begin
      vga_r_q <= pix_r;
      vga_g_q <= pix_g;
      vga_b_q <= pix_b;
    end else begin
      vga_r_q <= 8'd0;
      vga_g_q <= 8'd0;
      vga_b_q <= 8'd0;
    end
  end

  assign line_start  = run_q & (spotX == X_FIRST);
  assign frame_start = run_q & (spotX == X_FIRST) & (spotY == Y_FIRST);
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_blank   = blank_sr_q[PIPE_LAT];
  assign vga_hs      = hs_sr_q[PIPE_LAT];
  assign vga_vs      = vs_sr_q[PIPE_LAT];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-pixel lines with a shortened
// 9-line frame (VFP 2, VSYNC 2, VBP 1, VACTIVE 4) so a whole frame is short.
// A second instance with PIPE_LAT=3 checks the longer output delay.
module tb_vga_timing_gen;

  localparam int HT    = 1040;
  localparam int VT    = 9;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset_n;
  logic [7:0] pix_r, pix_g, pix_b;
  logic signed [10:0] spot_x, spot_y, spot_x3, spot_y3;
  logic fs, ls, fs3, ls3;
  logic [7:0] vr, vg, vb, vr3, vg3, vb3;
  logic hs, vs, blank, hs3, vs3, blank3;

  vga_timing_gen #(.VACTIVE(4), .VFP(2), .VSYNC(2), .VBP(1), .PIPE_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .spotX(spot_x), .spotY(spot_y),
    .frame_start(fs), .line_start(ls),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .vga_r(vr), .vga_g(vg), .vga_b(vb),
    .vga_hs(hs), .vga_vs(vs), .vga_blank(blank)
  );

  vga_timing_gen #(.VACTIVE(4), .VFP(2), .VSYNC(2), .VBP(1), .PIPE_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .spotX(spot_x3), .spotY(spot_y3),
    .frame_start(fs3), .line_start(ls3),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .vga_r(vr3), .vga_g(vg3), .vga_b(vb3),
    .vga_hs(hs3), .vga_vs(vs3), .vga_blank(blank3)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected spot for cycle c after release (c<0: the held first spot)
  function automatic int ex_x(input int c);
    return (c < 0) ? -240 : -240 + (c % HT);
  endfunction
  function automatic int ex_y(input int c);
    return (c < 0) ? -5 : -5 + ((c / HT) % VT);
  endfunction
  function automatic bit ex_act(input int c);
    return (ex_x(c) >= 0) && (ex_y(c) >= 0);
  endfunction

  initial begin
    int err_x, err_y, err_ls, err_fs, err_bl, err_hs, err_vs, err_col, err_bl3;
    int fs_cnt, ls_cnt, vs_cnt, hs_cnt, hs_first, nz_cnt, bl3_fall, x0_3;
    int n_cyc, found;
    err_x = 0; err_y = 0; err_ls = 0; err_fs = 0; err_bl = 0; err_hs = 0;
    err_vs = 0; err_col = 0; err_bl3 = 0;
    fs_cnt = 0; ls_cnt = 0; vs_cnt = 0; hs_cnt = 0; hs_first = -1; nz_cnt = 0;
    bl3_fall = -1; x0_3 = -1; found = 0;

    reset_n = 1'b0;
    pix_r = 8'd255; pix_g = 8'd255; pix_b = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_spotx", int'(spot_x), -240);
    check_eq("rst_spoty", int'(spot_y), -5);
    check_eq("rst_fs", int'(fs), 0);
    check_eq("rst_ls", int'(ls), 0);
    check_eq("rst_vga_r", int'(vr), 0);
    check_eq("rst_blank", int'(blank), 1);
    check_eq("rst_hs", int'(hs), 0);
    check_eq("rst_vs", int'(vs), 0);

    reset_n = 1'b1;
    n_cyc = FRAME + HT + 8;
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        check_eq("rel_spotx", int'(spot_x), -240);
        check_eq("rel_spoty", int'(spot_y), -5);
        check_eq("rel_fs", int'(fs), 1);
        check_eq("rel_ls", int'(ls), 1);
      end
      if (int'(spot_x) != ex_x(c)) err_x++;
      if (int'(spot_y) != ex_y(c)) err_y++;
      if (ls != (ex_x(c) == -240)) err_ls++;
      if (fs != ((ex_x(c) == -240) && (ex_y(c) == -5))) err_fs++;
      if (blank != !ex_act(c - 2)) err_bl++;
      if (hs != ((ex_x(c - 2) >= -184) && (ex_x(c - 2) <= -65))) err_hs++;
      if (vs != ((ex_y(c - 2) >= -3) && (ex_y(c - 2) <= -2))) err_vs++;
      if (int'(vr) != (ex_act(c - 2) ? 255 : 0) || vg != vr || vb != vr) err_col++;
      if ((vr != 8'd0) == blank) err_col++;
      if (blank3 != !ex_act(c - 4)) err_bl3++;
      if (c < FRAME && fs) fs_cnt++;
      if (c <= HT && ls) ls_cnt++;
      if (c >= 2 && c < FRAME + 2 && vs) vs_cnt++;
      if (c >= 2 && c < FRAME + 2 && vr != 8'd0) nz_cnt++;
      if (c < HT && hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (x0_3 < 0 && spot_x3 == 11'sd0 && spot_y3 >= 11'sd0) x0_3 = c;
      if (bl3_fall < 0 && blank3 == 1'b0) bl3_fall = c;
    end
    check_eq("spotx_track", err_x, 0);
    check_eq("spoty_track", err_y, 0);
    check_eq("line_start_track", err_ls, 0);
    check_eq("frame_start_track", err_fs, 0);
    check_eq("blank_track", err_bl, 0);
    check_eq("hs_track", err_hs, 0);
    check_eq("vs_track", err_vs, 0);
    check_eq("colour_track", err_col, 0);
    check_eq("blank3_track", err_bl3, 0);
    check_eq("fs_per_frame", fs_cnt, 1);
    check_eq("ls_in_first_line", ls_cnt, 2);
    check_eq("vs_cycles", vs_cnt, 2 * HT);
    check_eq("hs_cycles", hs_cnt, 120);
    check_eq("hs_start", hs_first, 58);
    check_eq("active_pixels", nz_cnt, 800 * 4);
    check_eq("x0_cycle_lat3", x0_3, 5 * HT + 240);
    check_eq("blank_fall_lat3", bl3_fall, 5 * HT + 240 + 4);

    // Mid-frame reset at spot (400,2)
    for (int k = 0; k < FRAME + 16 && found == 0; k++) begin
      if (spot_x == 11'sd400 && spot_y == 11'sd2) begin
        found = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("find_spot_400_2", found, 1);
    check_eq("pre_rst_blank", int'(blank), 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("mid_rst_spotx", int'(spot_x), -240);
    check_eq("mid_rst_spoty", int'(spot_y), -5);
    check_eq("mid_rst_fs", int'(fs), 0);
    check_eq("mid_rst_ls", int'(ls), 0);
    check_eq("mid_rst_vga_r", int'(vr), 0);
    check_eq("mid_rst_blank", int'(blank), 1);
    check_eq("mid_rst_hs", int'(hs), 0);
    check_eq("mid_rst_vs", int'(vs), 0);
    @(posedge clk);
    #1;
    check_eq("mid_rel_spotx", int'(spot_x), -240);
    check_eq("mid_rel_spoty", int'(spot_y), -5);
    check_eq("mid_rel_fs", int'(fs), 1);
    @(posedge clk);
    #1;
    check_eq("mid_rel_step", int'(spot_x), -239);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters: HACTIVE 800 (visible pixels per line); HFP 56, HSYNC 120, HBP 64 (horizontal porch/sync lengths, pixels); VACTIVE 600 (visible lines); VFP 37, VSYNC 6, VBP 23 (vertical porch/sync lengths, lines); PIPE_LAT 1 (renderer latency, cycles, range 0..4); HS_POL 1, VS_POL 1 (active sync level).
REQ-002 Ports: clk in 1 (pixel clock, 50 MHz); reset_n in 1 (reset, active-low, synchronous to clk).
REQ-003 Ports: spotX out signed 11, spotY out signed 11 (current pixel coordinate sent to renderers).
REQ-004 Ports: frame_start out 1 (first cycle of frame); line_start out 1 (first cycle of line).
REQ-005 Ports: pix_r, pix_g, pix_b in 8 each (renderer colour, PIPE_LAT cycles behind spot).
REQ-006 Ports: vga_r, vga_g, vga_b out 8 each; vga_hs, vga_vs, vga_blank out 1 (registered monitor outputs).

Function
REQ-007 Horizontal counter SHALL step once per clk through HBLANK=HFP+HSYNC+HBP plus HACTIVE positions (1040 default), then wrap.
REQ-008 spotX SHALL equal hpos-HBLANK: range -240..799; FP -240..-185, SYNC -184..-65, BP -64..-1, ACTIVE 0..799.
REQ-009 Vertical counter SHALL advance only in the cycle the horizontal counter wraps; spotY=vpos-VBLANK, range -66..599, same FP/SYNC/BP/ACTIVE order.
REQ-010 After spot (799,599), next spot SHALL be (-240,-66); no extra cycle at line or frame wrap.
REQ-011 Each axis SHALL be a 4-state FSM FP->SYNC->BP->ACTIVE->FP, driven by a per-phase down-counter loaded with phase length minus 1, advancing when it reaches 0.
REQ-012 Pixel active iff spotX>=0 and spotY>=0; raw hsync/vsync asserted iff the respective FSM is in SYNC.
REQ-013 line_start SHALL be 1 exactly when spotX=-240; frame_start exactly when spotX=-240 and spotY=-66; both aligned with spot, undelayed.
REQ-014 Raw hsync, vsync and blank (=not active) SHALL pass through a PIPE_LAT+1 deep shift register to vga_hs, vga_vs, vga_blank; sync outputs at HS_POL/VS_POL level when asserted.
REQ-015 vga_r/g/b SHALL register pix_r/g/b when the PIPE_LAT-delayed active flag is 1, else register 0; thus vga colour and vga_blank correspond to the same spot, PIPE_LAT+1 cycles after it appeared on spotX/spotY.
REQ-016 All output arithmetic in 11-bit signed; counters sized for 1040/666 without overflow; spotX/spotY never outside REQ-008/009 ranges.

Reset
REQ-017 While reset_n=0 at a clk edge: spotX=-240, spotY=-66, both FSMs in FP with counters loaded, frame_start=line_start=0, vga_r/g/b=0, vga_blank=1, vga_hs=!HS_POL, vga_vs=!VS_POL, delay line filled with blank=1, syncs inactive.
REQ-018 First cycle after reset_n rises: spot (-240,-66), frame_start=1, line_start=1.
REQ-019 Reset asserted mid-frame SHALL take effect at the next clk edge regardless of phase; no partial sync pulse beyond that edge.

Structure
REQ-020 Package vga_pkg SHALL hold timing localparams for 800x600@72 and the phase enum {PH_FP, PH_SYNC, PH_BP, PH_ACTIVE}.
REQ-021 One sub-module, vga_phase_ctr (parameterised phase lengths, advance-enable input, position/phase/wrap outputs), SHALL be instanced twice: horizontal (enable=1) and vertical (enable=horizontal wrap).

Verification
REQ-022 Release reset, run 1040 cycles -> spotX -240..799 monotonic, wraps to -240; line_start high exactly at cycles 0 and 1040.
REQ-023 Run one full frame (692640 cycles) -> frame_start pulses once per 692640 cycles; vga_vs active for exactly 6*1040 cycles per frame.
REQ-024 Count vga_hs per line -> active 120 cycles, starting 56 cycles after line start plus PIPE_LAT+1 delay.
REQ-025 Drive pix_r=g=b=255 constant, PIPE_LAT=1 -> vga_r nonzero exactly when vga_blank=0; 480000 nonzero cycles per frame.
REQ-026 Assert reset_n=0 for 1 cycle at spot (400,300) -> next cycle spot (-240,-66), outputs at REQ-017 values, then frame_start=1 on release.
REQ-027 Rebuild with PIPE_LAT=3 -> vga_blank falls exactly 4 cycles after spotX becomes 0 on an active line.
